// File: rtl/ram_loader_arbiter.sv
// ram_loader_arbiter: shares the single SDRAM Wishbone port between the core
// memory master and the HPS ROM loader halfword stream (clk_sys domain).
// Optional build macro LOADER_PACK_EN: pairs the two halfwords of one word
// into a single 32-bit write; without it every halfword is its own write.
module ram_loader_arbiter #(
   parameter logic [25:0] LOAD_BASE = 26'h400000,
   parameter int unsigned LOAD_AW   = 24
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ld_active,
   input  logic        ld_wr,
   input  logic [24:0] ld_addr,
   input  logic [15:0] ld_data,
   output logic        ld_wait,
   input  logic        core_stb,
   input  logic        core_we,
   input  logic [3:0]  core_sel,
   input  logic [21:0] core_adr,
   input  logic [31:0] core_dat,
   input  logic [2:0]  core_cti,
   output logic        core_ack,
   output logic        ram_stb,
   output logic        ram_we,
   output logic [3:0]  ram_sel,
   output logic [25:0] ram_adr,
   output logic [31:0] ram_dat,
   output logic [2:0]  ram_cti,
   input  logic        ram_ack
);

   typedef enum logic [1:0] {S_IDLE, S_CORE, S_LDWR} state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   // Pending loader write, fully formed at capture time so LDWR drives registers
   logic        r_pend;
   logic        r_ld_wait;
   logic [25:0] r_wr_adr;
   logic [3:0]  r_wr_sel;
   logic [31:0] r_wr_dat;

   logic [25:0] w_ld_adr;
   logic        w_capture;
   logic        w_ldwr_done;
   logic        w_unused;

   assign w_ld_adr    = LOAD_BASE + {{(26-LOAD_AW){1'b0}}, ld_addr[LOAD_AW-1:2], 2'b00};
   assign w_capture   = ld_active && ld_wr && !r_ld_wait;
   assign w_ldwr_done = (r_state == S_LDWR) && ram_ack;
   assign w_unused    = ^ld_addr;
   assign ld_wait     = r_ld_wait;

   // Arbitration state register
   always_ff @(posedge clk_sys) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state selection and SDRAM/core port steering
   always_comb begin
      w_state_nxt = r_state;
      ram_stb     = 1'b0;
      ram_we      = 1'b0;
      ram_sel     = '0;
      ram_adr     = '0;
      ram_dat     = '0;
      ram_cti     = '0;
      core_ack    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_pend)                       w_state_nxt = S_LDWR;
            else if (core_stb && !ld_active)  w_state_nxt = S_CORE;
         end
         S_CORE: begin
            ram_stb  = core_stb;
            ram_we   = core_we;
            ram_sel  = core_sel;
            ram_adr  = {2'b00, core_adr, 2'b00};
            ram_dat  = core_dat;
            ram_cti  = core_cti;
            core_ack = ram_ack;
            // Only an incrementing-burst beat keeps the grant; anything else ends it
            if (!core_stb)                             w_state_nxt = S_IDLE;
            else if (ram_ack && core_cti != 3'b010)    w_state_nxt = S_IDLE;
         end
         S_LDWR: begin
            ram_stb = 1'b1;
            ram_we  = 1'b1;
            ram_sel = r_wr_sel;
            ram_adr = r_wr_adr;
            ram_dat = r_wr_dat;
            if (ram_ack) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

`ifdef LOADER_PACK_EN
   // Held low halfword waiting for its partner, plus a queued high halfword
   // that must follow a flush when a different word arrives.
   logic        r_held;
   logic [25:0] r_held_adr;
   logic [15:0] r_held_dat;
   logic        r_pend2;
   logic [25:0] r_p2_adr;
   logic [15:0] r_p2_dat;

   // Loader capture, pairing and flush sequencing
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_pend     <= 1'b0;
         r_ld_wait  <= 1'b0;
         r_wr_adr   <= '0;
         r_wr_sel   <= '0;
         r_wr_dat   <= '0;
         r_held     <= 1'b0;
         r_held_adr <= '0;
         r_held_dat <= '0;
         r_pend2    <= 1'b0;
         r_p2_adr   <= '0;
         r_p2_dat   <= '0;
      end else if (w_ldwr_done) begin
         if (r_pend2) begin
            r_wr_adr <= r_p2_adr;
            r_wr_sel <= 4'b1100;
            r_wr_dat <= {r_p2_dat, r_p2_dat};
            r_pend2  <= 1'b0;
         end else begin
            r_pend    <= 1'b0;
            r_ld_wait <= 1'b0;
         end
      end else if (r_ld_wait && !r_pend) begin
         // Low half was only held, not written: release back-pressure after one cycle
         r_ld_wait <= 1'b0;
      end else if (!ld_active && r_held && !r_ld_wait) begin
         r_wr_adr  <= r_held_adr;
         r_wr_sel  <= 4'b0011;
         r_wr_dat  <= {r_held_dat, r_held_dat};
         r_pend    <= 1'b1;
         r_ld_wait <= 1'b1;
         r_held    <= 1'b0;
      end else if (w_capture) begin
         r_ld_wait <= 1'b1;
         if (!ld_addr[1]) begin
            r_held     <= 1'b1;
            r_held_adr <= w_ld_adr;
            r_held_dat <= ld_data;
            if (r_held) begin
               r_wr_adr <= r_held_adr;
               r_wr_sel <= 4'b0011;
               r_wr_dat <= {r_held_dat, r_held_dat};
               r_pend   <= 1'b1;
            end
         end else if (r_held && r_held_adr == w_ld_adr) begin
            r_wr_adr <= w_ld_adr;
            r_wr_sel <= 4'b1111;
            r_wr_dat <= {ld_data, r_held_dat};
            r_pend   <= 1'b1;
            r_held   <= 1'b0;
         end else if (r_held) begin
            r_wr_adr <= r_held_adr;
            r_wr_sel <= 4'b0011;
            r_wr_dat <= {r_held_dat, r_held_dat};
            r_pend   <= 1'b1;
            r_pend2  <= 1'b1;
            r_p2_adr <= w_ld_adr;
            r_p2_dat <= ld_data;
            r_held   <= 1'b0;
         end else begin
            r_wr_adr <= w_ld_adr;
            r_wr_sel <= 4'b1100;
            r_wr_dat <= {ld_data, ld_data};
            r_pend   <= 1'b1;
         end
      end
   end
`else
   // Loader capture: one halfword in flight, back-pressure until it is written
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_pend    <= 1'b0;
         r_ld_wait <= 1'b0;
         r_wr_adr  <= '0;
         r_wr_sel  <= '0;
         r_wr_dat  <= '0;
      end else if (w_ldwr_done) begin
         r_pend    <= 1'b0;
         r_ld_wait <= 1'b0;
      end else if (w_capture) begin
         r_wr_adr  <= w_ld_adr;
         r_wr_sel  <= ld_addr[1] ? 4'b1100 : 4'b0011;
         r_wr_dat  <= {ld_data, ld_data};
         r_pend    <= 1'b1;
         r_ld_wait <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ram_loader_arbiter.sv
// Scoreboard bench for ram_loader_arbiter: expected SDRAM transfers are queued
// by the stimulus and checked by an independent monitor on every ram ack.
module tb_ram_loader_arbiter;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ld_active, ld_wr;
   logic [24:0] ld_addr;
   logic [15:0] ld_data;
   logic        ld_wait;
   logic        core_stb, core_we;
   logic [3:0]  core_sel;
   logic [21:0] core_adr;
   logic [31:0] core_dat;
   logic [2:0]  core_cti;
   logic        core_ack;
   logic        ram_stb, ram_we;
   logic [3:0]  ram_sel;
   logic [25:0] ram_adr;
   logic [31:0] ram_dat;
   logic [2:0]  ram_cti;
   logic        ram_ack;

   logic        ack_en;
   logic        force_ack;

   typedef struct packed {
      logic [25:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        we;
      logic [2:0]  cti;
   } xact_t;

   xact_t       q[$];
   int          total = 0;
   int          bad = 0;
   int          nwrites = 0;
   int          g_core_acks = 0;

   ram_loader_arbiter dut (
      .clk_sys(clk_sys), .reset(reset),
      .ld_active(ld_active), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_wait(ld_wait),
      .core_stb(core_stb), .core_we(core_we), .core_sel(core_sel), .core_adr(core_adr),
      .core_dat(core_dat), .core_cti(core_cti), .core_ack(core_ack),
      .ram_stb(ram_stb), .ram_we(ram_we), .ram_sel(ram_sel), .ram_adr(ram_adr),
      .ram_dat(ram_dat), .ram_cti(ram_cti), .ram_ack(ram_ack)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // SDRAM model: acks every other cycle while strobed; force_ack injects a stray ack
   initial begin
      ram_ack = 1'b0;
      forever begin
         @(posedge clk_sys);
         #2;
         ram_ack = force_ack | (ack_en & ram_stb & ~ram_ack);
      end
   end

   // Monitor: every completed SDRAM transfer must match the head of the queue
   initial begin
      xact_t e;
      forever begin
         @(negedge clk_sys);
         if (!reset && ram_stb && ram_ack) begin
            nwrites++;
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL ram_unexpected: adr=%h sel=%h dat=%h, none expected",
                        ram_adr, ram_sel, ram_dat);
            end else begin
               e = q.pop_front();
               chk("ram_xfer", 80'({ram_adr, ram_sel, ram_dat, ram_we, ram_cti}), 80'(e));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic ld_write(input logic [24:0] a, input logic [15:0] d, input bit push,
                           input logic [25:0] ea, input logic [3:0] es, input logic [31:0] ed);
      if (push) q.push_back('{ea, es, ed, 1'b1, 3'b000});
      ld_addr = a;
      ld_data = d;
      ld_wr   = 1'b1;
      @(posedge clk_sys);
      #1;
      ld_wr   = 1'b0;
   endtask

   task automatic wait_free(input string name);
      int cnt = 0;
      while (ld_wait && cnt < 200) begin
         @(negedge clk_sys);
         cnt++;
      end
      chk(name, 80'(ld_wait), 80'(0));
   endtask

   task automatic core_burst(input logic [21:0] a, input int unsigned n);
      int unsigned acks = 0;
      for (int unsigned i = 0; i < n; i++) begin
         logic [21:0] ad;
         logic [2:0]  ct;
         ad = 22'(a + i);
         ct = (n == 1) ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
         q.push_back('{{2'b00, ad, 2'b00}, 4'hF, 32'hA5A50000 ^ {10'h0, ad}, 1'b1, ct});
      end
      for (int unsigned i = 0; i < n; i++) begin
         int  cnt = 0;
         bit  acked = 0;
         core_stb = 1'b1;
         core_we  = 1'b1;
         core_sel = 4'hF;
         core_adr = 22'(a + i);
         core_dat = 32'hA5A50000 ^ {10'h0, core_adr};
         core_cti = (n == 1) ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
         while (!acked && cnt < 200) begin
            @(negedge clk_sys);
            acked = core_ack;
            cnt++;
         end
         if (acked) begin
            acks++;
            g_core_acks++;
         end
         @(posedge clk_sys);
         #1;
      end
      core_stb = 1'b0;
      core_cti = 3'b000;
      chk("core_acks", 80'(acks), 80'(n));
   endtask

   initial begin
      int w0;
      int base;
      int cnt;
      bit seen;
      reset = 1'b1; ld_active = 0; ld_wr = 0; ld_addr = '0; ld_data = '0;
      core_stb = 0; core_we = 0; core_sel = '0; core_adr = '0; core_dat = '0; core_cti = '0;
      ack_en = 1'b1; force_ack = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1 reset = 1'b0;
      @(negedge clk_sys);
      chk("reset_state", 80'({ld_wait, core_ack, ram_stb, ram_we, ram_sel, ram_cti}), 80'(0));

      // Single loader halfword at odd halfword slot
      ld_active = 1'b1;
      ld_write(25'h000006, 16'hBEEF, 1, 26'h400004, 4'b1100, 32'hBEEFBEEF);
      chk("ld_wait_set", 80'(ld_wait), 80'(1));
      cnt = 0;
      while (!(ram_stb && ram_ack) && cnt < 50) begin
         @(negedge clk_sys);
         cnt++;
      end
      chk("ld_wait_at_ack", 80'(ld_wait), 80'(1));
      @(negedge clk_sys);
      chk("ld_wait_after_ack", 80'(ld_wait), 80'(0));

      // Top of loader window and an ignored address bit above LOAD_AW
      ld_write(25'h0FFFFFE, 16'h1234, 1, 26'h13FFFFC, 4'b1100, 32'h12341234);
      wait_free("free_top");
      ld_write(25'h100000A, 16'h5678, 1, 26'h400008, 4'b1100, 32'h56785678);
      wait_free("free_hibit");

      // Strobe outside the download window is ignored
      ld_active = 1'b0;
      ld_write(25'h000010, 16'hDEAD, 0, '0, '0, '0);
      @(negedge clk_sys);
      chk("ignored_wr_wait", 80'(ld_wait), 80'(0));
      repeat (4) @(posedge clk_sys);
      #1;

      // Second strobe while ld_wait is high is dropped
      ld_active = 1'b1;
      w0 = nwrites;
      ld_write(25'h000102, 16'hAAAA, 1, 26'h400100, 4'b1100, 32'hAAAAAAAA);
      ld_write(25'h000106, 16'hBBBB, 0, '0, '0, '0);
      wait_free("free_drop");
      repeat (3) @(posedge clk_sys);
      #1;
      chk("dropped_wr_count", 80'(nwrites - w0), 80'(1));

      // Core burst of four with a loader write captured on beat two
      ld_active = 1'b0;
      base = g_core_acks;
      fork
         core_burst(22'h000200, 4);
         begin
            int c2 = 0;
            while (g_core_acks < base + 1 && c2 < 200) begin
               @(posedge clk_sys);
               c2++;
            end
            #1;
            ld_active = 1'b1;
            ld_write(25'h00000A, 16'h4242, 1, 26'h400008, 4'b1100, 32'h42424242);
         end
      join
      wait_free("free_after_burst");
      ld_active = 1'b0;

      // Core held off for the whole download window, served afterwards
      ld_active = 1'b1;
      seen = 0;
      fork
         core_burst(22'h000100, 1);
         begin
            repeat (10) begin
               @(negedge clk_sys);
               if (core_ack || ram_stb) seen = 1;
            end
            ld_active = 1'b0;
         end
      join
      chk("core_blocked", 80'(seen), 80'(0));

      // Reset while a loader write is on the bus; stray ack afterwards
      ack_en = 1'b0;
      ld_active = 1'b1;
      ld_write(25'h00000E, 16'h9999, 0, '0, '0, '0);
      cnt = 0;
      while (!ram_stb && cnt < 50) begin
         @(negedge clk_sys);
         cnt++;
      end
      chk("ldwr_reached", 80'({ram_stb, ram_we, ram_sel}), 80'(6'b111100));
      @(posedge clk_sys);
      #1 reset = 1'b1;
      @(posedge clk_sys);
      #1;
      chk("reset_mid_ldwr", 80'({ram_stb, ld_wait, core_ack}), 80'(0));
      reset = 1'b0;
      ld_active = 1'b0;
      ack_en = 1'b1;
      force_ack = 1'b1;
      @(posedge clk_sys);
      #1 force_ack = 1'b0;
      @(posedge clk_sys);
      @(negedge clk_sys);
      chk("late_ack_idle", 80'({ram_stb, ld_wait, core_ack}), 80'(0));
      ld_active = 1'b1;
      ld_write(25'h000002, 16'h5A5A, 1, 26'h400000, 4'b1100, 32'h5A5A5A5A);
      wait_free("free_after_reset");

`ifdef LOADER_PACK_EN
      ld_write(25'h000000, 16'h1111, 1, 26'h400000, 4'b1111, 32'h22221111);
      wait_free("free_pack_lo");
      ld_write(25'h000002, 16'h2222, 0, '0, '0, '0);
      wait_free("free_pack_hi");
      ld_write(25'h000004, 16'h3333, 1, 26'h400004, 4'b0011, 32'h33333333);
      wait_free("free_pack_hold");
      ld_active = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      wait_free("free_pack_flush");
`else
      ld_write(25'h000000, 16'h1111, 1, 26'h400000, 4'b0011, 32'h11111111);
      wait_free("free_lo");
      ld_write(25'h000002, 16'h2222, 1, 26'h400000, 4'b1100, 32'h22222222);
      wait_free("free_hi");
      ld_write(25'h000004, 16'h3333, 1, 26'h400004, 4'b0011, 32'h33333333);
      wait_free("free_lone");
      ld_active = 1'b0;
`endif

      repeat (6) @(posedge clk_sys);
      #1;
      chk("scoreboard_drained", 80'(q.size()), 80'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
